// File: rtl/icp_mem_arbiter.sv
// Round-robin arbiter sharing one registered memory port between NUM_REQ requesters.
// Define ICP_ARB_LOCK_EN to let a requester hold the grant across consecutive requests.
module icp_mem_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned ADDR_W  = 13,
    parameter int unsigned DATA_W  = 64,
    parameter int unsigned MEM_LAT = 1
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [NUM_REQ-1:0]        i_req_valid,
    input  logic [2*NUM_REQ-1:0]      i_req_op,
    input  logic [ADDR_W*NUM_REQ-1:0] i_req_addr,
    input  logic [DATA_W*NUM_REQ-1:0] i_req_wdata,
    input  logic [NUM_REQ-1:0]        i_req_lock,
    output logic [NUM_REQ-1:0]        o_req_ready,
    output logic [NUM_REQ-1:0]        o_rsp_valid,
    output logic [DATA_W-1:0]         o_rsp_data,
    output logic [1:0]                o_mem_op,
    output logic [ADDR_W-1:0]         o_mem_addr,
    output logic [DATA_W-1:0]         o_mem_wdata,
    input  logic [DATA_W-1:0]         i_mem_rdata
);

    localparam int unsigned IdW     = $clog2(NUM_REQ);
    localparam logic [1:0]  OpNone  = 2'd0;
    localparam logic [1:0]  OpRead  = 2'd1;
    localparam logic [1:0]  OpWrite = 2'd2;

    logic [IdW-1:0]               last_grant_q;
    logic [NUM_REQ-1:0]           cand;
    logic [NUM_REQ-1:0]           grant_oh;
    logic [IdW-1:0]               grant_id;
    logic                         found;
    logic [IdW-1:0]               idx;
    logic                         accept;
    logic [1:0]                   grant_op;

    // Read tracker: stage MEM_LAT holds the read whose data is on i_mem_rdata now.
    logic [MEM_LAT:0]             pipe_vld_q;
    logic [MEM_LAT:0][IdW-1:0]    pipe_id_q;
    logic [NUM_REQ-1:0]           rsp_valid_q;
    logic [DATA_W-1:0]            rsp_data_q;
    logic [1:0]                   mem_op_q;
    logic [ADDR_W-1:0]            mem_addr_q;
    logic [DATA_W-1:0]            mem_wdata_q;

`ifdef ICP_ARB_LOCK_EN
    logic                         locked_q;
    logic [IdW-1:0]               owner_q;
    logic                         lock_hold;
    logic [NUM_REQ-1:0]           owner_oh;

    always_comb begin
        owner_oh  = '0;
        owner_oh[owner_q] = 1'b1;
        // Owner keeps the lock while it still asserts either valid or lock.
        lock_hold = locked_q && (i_req_valid[owner_q] || i_req_lock[owner_q]);
        cand      = lock_hold ? (i_req_valid & owner_oh) : i_req_valid;
    end
`else
    logic unused_lock;
    assign unused_lock = ^i_req_lock;
    assign cand        = i_req_valid;
`endif

    always_comb begin
        found    = 1'b0;
        grant_id = '0;
        grant_oh = '0;
        idx      = '0;
        for (int i = 1; i <= int'(NUM_REQ); i++) begin
            idx = IdW'((int'(last_grant_q) + i) % int'(NUM_REQ));
            if (!found && cand[idx]) begin
                found    = 1'b1;
                grant_id = idx;
            end
        end
        if (found && !i_rst) begin
            grant_oh[grant_id] = 1'b1;
        end
    end

    assign accept   = |grant_oh;
    assign grant_op = i_req_op[2*grant_id +: 2];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            last_grant_q <= IdW'(NUM_REQ - 1);
            pipe_vld_q   <= '0;
            pipe_id_q    <= '0;
            rsp_valid_q  <= '0;
            rsp_data_q   <= '0;
            mem_op_q     <= OpNone;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
`ifdef ICP_ARB_LOCK_EN
            locked_q     <= 1'b0;
            owner_q      <= '0;
`endif
        end else begin
            mem_op_q      <= OpNone;
            pipe_vld_q[0] <= 1'b0;
            pipe_id_q[0]  <= grant_id;
            if (accept) begin
                last_grant_q <= grant_id;
                mem_addr_q   <= i_req_addr[ADDR_W*grant_id +: ADDR_W];
                mem_wdata_q  <= i_req_wdata[DATA_W*grant_id +: DATA_W];
                if (grant_op == OpRead || grant_op == OpWrite) begin
                    mem_op_q <= grant_op;
                end
                pipe_vld_q[0] <= (grant_op == OpRead);
            end
            for (int s = 1; s <= int'(MEM_LAT); s++) begin
                pipe_vld_q[s] <= pipe_vld_q[s-1];
                pipe_id_q[s]  <= pipe_id_q[s-1];
            end
            rsp_valid_q <= '0;
            if (pipe_vld_q[MEM_LAT]) begin
                rsp_valid_q[pipe_id_q[MEM_LAT]] <= 1'b1;
                rsp_data_q                      <= i_mem_rdata;
            end
`ifdef ICP_ARB_LOCK_EN
            if (accept) begin
                locked_q <= i_req_lock[grant_id];
                owner_q  <= grant_id;
            end else if (!lock_hold) begin
                locked_q <= 1'b0;
            end
`endif
        end
    end

    assign o_req_ready = grant_oh;
    assign o_rsp_valid = rsp_valid_q;
    assign o_rsp_data  = rsp_data_q;
    assign o_mem_op    = mem_op_q;
    assign o_mem_addr  = mem_addr_q;
    assign o_mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_icp_mem_arbiter.sv
// Directed bench for icp_mem_arbiter (2 requesters, MEM_LAT=1) with a synchronous memory model.
module tb_icp_mem_arbiter;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [1:0]   req_valid = '0;
    logic [3:0]   req_op = '0;
    logic [25:0]  req_addr = '0;
    logic [127:0] req_wdata = '0;
    logic [1:0]   req_lock = '0;
    logic [1:0]   req_ready;
    logic [1:0]   rsp_valid;
    logic [63:0]  rsp_data;
    logic [1:0]   mem_op;
    logic [12:0]  mem_addr;
    logic [63:0]  mem_wdata;
    logic [63:0]  mem_rdata = '0;
    logic [63:0]  mem [0:8191];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    icp_mem_arbiter dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_req_valid (req_valid),
        .i_req_op    (req_op),
        .i_req_addr  (req_addr),
        .i_req_wdata (req_wdata),
        .i_req_lock  (req_lock),
        .o_req_ready (req_ready),
        .o_rsp_valid (rsp_valid),
        .o_rsp_data  (rsp_data),
        .o_mem_op    (mem_op),
        .o_mem_addr  (mem_addr),
        .o_mem_wdata (mem_wdata),
        .i_mem_rdata (mem_rdata)
    );

    // One-cycle read latency memory, write committed while o_mem_op=WRITE.
    always @(posedge clk) begin
        if (mem_op == 2'd2) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int r, input logic v, input logic [1:0] op,
                           input logic [12:0] addr, input logic [63:0] wd, input logic lk);
        req_valid[r]         = v;
        req_op[2*r +: 2]     = op;
        req_addr[13*r +: 13] = addr;
        req_wdata[64*r +: 64] = wd;
        req_lock[r]          = lk;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        n_cmp++; if (mem_op !== 2'd0) begin n_err++; $display("FAIL reset_mem_op got %0h want 0", mem_op); end
        n_cmp++; if (req_ready !== 2'b00) begin n_err++; $display("FAIL reset_ready got %b want 00", req_ready); end
        n_cmp++; if (rsp_valid !== 2'b00) begin n_err++; $display("FAIL reset_rsp_valid got %b want 00", rsp_valid); end
        n_cmp++; if (rsp_data !== 64'd0) begin n_err++; $display("FAIL reset_rsp_data got %0h want 0", rsp_data); end
        n_cmp++; if (mem_addr !== 13'd0) begin n_err++; $display("FAIL reset_mem_addr got %0h want 0", mem_addr); end
    endtask

    task automatic test_read();
        set_req(0, 1'b1, 2'd1, 13'h5, 64'd0, 1'b0);
        #1;
        n_cmp++; if (req_ready !== 2'b01) begin n_err++; $display("FAIL read_ready got %b want 01", req_ready); end
        tick();
        set_req(0, 1'b0, 2'd0, 13'h0, 64'd0, 1'b0);
        n_cmp++; if (mem_op !== 2'd1) begin n_err++; $display("FAIL read_mem_op got %0h want 1", mem_op); end
        n_cmp++; if (mem_addr !== 13'h5) begin n_err++; $display("FAIL read_mem_addr got %0h want 5", mem_addr); end
        tick();
        n_cmp++; if (mem_op !== 2'd0) begin n_err++; $display("FAIL read_op_one_cycle got %0h want 0", mem_op); end
        n_cmp++; if (rsp_valid !== 2'b00) begin n_err++; $display("FAIL read_rsp_early got %b want 00", rsp_valid); end
        tick();
        n_cmp++; if (rsp_valid !== 2'b01) begin n_err++; $display("FAIL read_rsp_valid got %b want 01", rsp_valid); end
        n_cmp++; if (rsp_data !== 64'h2A) begin n_err++; $display("FAIL read_rsp_data got %0h want 2a", rsp_data); end
        tick();
        n_cmp++; if (rsp_valid !== 2'b00) begin n_err++; $display("FAIL read_rsp_pulse got %b want 00", rsp_valid); end
        n_cmp++; if (rsp_data !== 64'h2A) begin n_err++; $display("FAIL read_rsp_hold got %0h want 2a", rsp_data); end
    endtask

    task automatic test_write_read();
        int p1 = 0;
        int p0 = 0;
        logic [63:0] got = '0;
        set_req(1, 1'b1, 2'd2, 13'h10, 64'hDEAD, 1'b0);
        #1;
        n_cmp++; if (req_ready !== 2'b10) begin n_err++; $display("FAIL wr_ready got %b want 10", req_ready); end
        tick();
        n_cmp++; if (mem_op !== 2'd2) begin n_err++; $display("FAIL wr_mem_op got %0h want 2", mem_op); end
        n_cmp++; if (mem_wdata !== 64'hDEAD) begin n_err++; $display("FAIL wr_wdata got %0h want dead", mem_wdata); end
        set_req(1, 1'b1, 2'd1, 13'h10, 64'd0, 1'b0);
        #1;
        n_cmp++; if (req_ready !== 2'b10) begin n_err++; $display("FAIL rd1_ready got %b want 10", req_ready); end
        tick();
        n_cmp++; if (mem_op !== 2'd1) begin n_err++; $display("FAIL rd1_mem_op got %0h want 1", mem_op); end
        set_req(1, 1'b0, 2'd0, 13'h0, 64'd0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            if (rsp_valid[1]) begin p1++; got = rsp_data; end
            if (rsp_valid[0]) p0++;
        end
        n_cmp++; if (p1 !== 1) begin n_err++; $display("FAIL wr_rd_pulses1 got %0d want 1", p1); end
        n_cmp++; if (p0 !== 0) begin n_err++; $display("FAIL wr_rd_pulses0 got %0d want 0", p0); end
        n_cmp++; if (got !== 64'hDEAD) begin n_err++; $display("FAIL wr_rd_data got %0h want dead", got); end
    endtask

    task automatic test_back_to_back();
        int c0 = 0;
        int c1 = 0;
        int exp = 0;
        set_req(0, 1'b1, 2'd2, 13'h20, 64'h100, 1'b0);
        set_req(1, 1'b1, 2'd2, 13'h21, 64'h101, 1'b0);
        for (int i = 0; i < 8; i++) begin
            #1;
            n_cmp++;
            if (req_ready !== (exp == 0 ? 2'b01 : 2'b10)) begin
                n_err++; $display("FAIL b2b_ready[%0d] got %b want grant %0d", i, req_ready, exp);
            end
            tick();
            n_cmp++; if (mem_op !== 2'd2) begin n_err++; $display("FAIL b2b_op[%0d] got %0h want 2", i, mem_op); end
            n_cmp++;
            if (mem_addr !== 13'(32 + exp)) begin
                n_err++; $display("FAIL b2b_addr[%0d] got %0h want %0h", i, mem_addr, 32 + exp);
            end
            if (mem_addr == 13'h20) c0++;
            if (mem_addr == 13'h21) c1++;
            exp = 1 - exp;
        end
        set_req(0, 1'b0, 2'd0, 13'h0, 64'd0, 1'b0);
        set_req(1, 1'b0, 2'd0, 13'h0, 64'd0, 1'b0);
        n_cmp++; if (c0 !== 4) begin n_err++; $display("FAIL b2b_count0 got %0d want 4", c0); end
        n_cmp++; if (c1 !== 4) begin n_err++; $display("FAIL b2b_count1 got %0d want 4", c1); end
        tick();
    endtask

    task automatic test_reserved();
        int p = 0;
        set_req(0, 1'b1, 2'd3, 13'h7, 64'd0, 1'b0);
        #1;
        n_cmp++; if (req_ready !== 2'b01) begin n_err++; $display("FAIL rsv_ready got %b want 01", req_ready); end
        tick();
        set_req(0, 1'b0, 2'd0, 13'h0, 64'd0, 1'b0);
        n_cmp++; if (mem_op !== 2'd0) begin n_err++; $display("FAIL rsv_mem_op got %0h want 0", mem_op); end
        for (int i = 0; i < 4; i++) begin
            tick();
            if (rsp_valid != 2'b00) p++;
        end
        n_cmp++; if (p !== 0) begin n_err++; $display("FAIL rsv_rsp got %0d pulses want 0", p); end
    endtask

    task automatic test_mid_reset();
        int p = 0;
        set_req(1, 1'b1, 2'd1, 13'h10, 64'd0, 1'b0);
        #1;
        n_cmp++; if (req_ready !== 2'b10) begin n_err++; $display("FAIL mrst_ready got %b want 10", req_ready); end
        tick();
        n_cmp++; if (mem_op !== 2'd1) begin n_err++; $display("FAIL mrst_mem_op got %0h want 1", mem_op); end
        set_req(1, 1'b0, 2'd0, 13'h0, 64'd0, 1'b0);
        rst = 1'b1;
        tick();
        n_cmp++; if (mem_op !== 2'd0) begin n_err++; $display("FAIL mrst_op got %0h want 0", mem_op); end
        n_cmp++; if (mem_addr !== 13'd0) begin n_err++; $display("FAIL mrst_addr got %0h want 0", mem_addr); end
        n_cmp++; if (rsp_data !== 64'd0) begin n_err++; $display("FAIL mrst_rsp_data got %0h want 0", rsp_data); end
        n_cmp++; if (rsp_valid !== 2'b00) begin n_err++; $display("FAIL mrst_rsp_valid got %b want 00", rsp_valid); end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (rsp_valid != 2'b00) p++;
        end
        n_cmp++; if (p !== 0) begin n_err++; $display("FAIL mrst_rsp got %0d pulses want 0", p); end
        set_req(0, 1'b1, 2'd0, 13'h0, 64'd0, 1'b0);
        set_req(1, 1'b1, 2'd0, 13'h0, 64'd0, 1'b0);
        #1;
        n_cmp++; if (req_ready !== 2'b01) begin n_err++; $display("FAIL mrst_priority got %b want 01", req_ready); end
        set_req(0, 1'b0, 2'd0, 13'h0, 64'd0, 1'b0);
        set_req(1, 1'b0, 2'd0, 13'h0, 64'd0, 1'b0);
        tick();
    endtask

`ifdef ICP_ARB_LOCK_EN
    task automatic test_lock();
        set_req(0, 1'b1, 2'd1, 13'h5, 64'd0, 1'b1);
        set_req(1, 1'b1, 2'd2, 13'h30, 64'h55, 1'b0);
        #1;
        n_cmp++; if (req_ready !== 2'b01) begin n_err++; $display("FAIL lock_g1 got %b want 01", req_ready); end
        tick();
        n_cmp++; if (mem_addr !== 13'h5) begin n_err++; $display("FAIL lock_a1 got %0h want 5", mem_addr); end
        set_req(0, 1'b1, 2'd2, 13'h31, 64'h7, 1'b0);
        #1;
        n_cmp++; if (req_ready !== 2'b01) begin n_err++; $display("FAIL lock_g2 got %b want 01", req_ready); end
        tick();
        n_cmp++; if (mem_addr !== 13'h31) begin n_err++; $display("FAIL lock_a2 got %0h want 31", mem_addr); end
        set_req(0, 1'b0, 2'd0, 13'h0, 64'd0, 1'b0);
        #1;
        n_cmp++; if (req_ready !== 2'b10) begin n_err++; $display("FAIL lock_g3 got %b want 10", req_ready); end
        tick();
        n_cmp++; if (mem_addr !== 13'h30) begin n_err++; $display("FAIL lock_a3 got %0h want 30", mem_addr); end
        set_req(1, 1'b0, 2'd0, 13'h0, 64'd0, 1'b0);
        repeat (3) tick();
    endtask
`endif

    initial begin
        mem[5] = 64'h2A;
        test_reset();
        test_read();
        test_write_read();
        test_back_to_back();
        test_reserved();
        test_mid_reset();
`ifdef ICP_ARB_LOCK_EN
        test_lock();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
